// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP, reset vector
// and the fetch-buffer entry layout.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a 32-bit instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer holding {pc, instr} entries between instruction memory
// and the ID stage. Head is read combinationally so a pop can feed ID in the
// same cycle. Push on full (without pop) and pop on empty are ignored.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic push_ok;
    logic pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign pop_ok  = pop && !empty;
    // A push on a full buffer is only safe when the head leaves the same cycle.
    assign push_ok = push && (!full || pop_ok);

    // Per-entry storage write: only the slot under the write pointer updates.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush discards every entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential requests to instruction memory,
// tracks outstanding requests, drops stale responses after a redirect and
// presents one instruction per cycle to ID through a small buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;   // address of oldest live request
    logic [1:0]      inflight_reg, inflight_next;
    logic [1:0]      drop_reg, drop_next;
    logic            id_valid_reg, id_valid_next;
    logic [XLEN-1:0] id_pc_reg, id_pc_next;
    logic [XLEN-1:0] id_instr_reg, id_instr_next;

    logic            req_fire;
    logic            rsp_counted;
    logic            rsp_drop;
    logic            rsp_live;
    logic [2:0]      occupancy;

    logic            buf_flush;
    logic            buf_push;
    logic            buf_pop;
    fetch_entry_t    buf_push_data;
    fetch_entry_t    buf_head;
    logic [CW-1:0]   buf_count;
    logic            buf_full;
    logic            buf_empty;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (buf_flush),
        .push      (buf_push),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Every request must have a guaranteed buffer slot, so outstanding
    // requests plus buffered entries never exceed the buffer depth.
    assign occupancy      = {1'b0, inflight_reg} + 3'(buf_count);
    assign imem_req_valid = !rst && !redirect_valid && (occupancy < 3'(BUF_DEPTH));
    assign imem_req_addr  = {pc_reg[XLEN-1:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are spurious; stale ones are dropped.
    assign rsp_counted = imem_rsp_valid && (inflight_reg != 2'd0);
    assign rsp_drop    = rsp_counted && (drop_reg != 2'd0);
    assign rsp_live    = rsp_counted && (drop_reg == 2'd0) && !redirect_valid;

    assign buf_push_data = '{pc: rsp_pc_reg, instr: imem_rsp_data};

    assign id_valid = id_valid_reg;
    assign id_pc    = id_pc_reg;
    assign id_instr = id_instr_reg;

    // Next-state logic: redirect flushes everything, otherwise feed ID from
    // the buffer head first, then directly from a live response.
    always_comb begin
        pc_next        = pc_reg;
        rsp_pc_next    = rsp_pc_reg;
        inflight_next  = inflight_reg;
        drop_next      = drop_reg;
        id_valid_next  = id_valid_reg;
        id_pc_next     = id_pc_reg;
        id_instr_next  = id_instr_reg;
        buf_flush      = 1'b0;
        buf_push       = 1'b0;
        buf_pop        = 1'b0;

        if (redirect_valid) begin
            pc_next       = align_pc(redirect_pc);
            rsp_pc_next   = align_pc(redirect_pc);
            inflight_next = inflight_reg - 2'(rsp_counted);
            drop_next     = inflight_reg - 2'(rsp_counted);
            id_valid_next = 1'b0;
            id_instr_next = NOP_INSTR;
            buf_flush     = 1'b1;
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + 32'd4;
            end
            inflight_next = inflight_reg + 2'(req_fire) - 2'(rsp_counted);
            if (rsp_drop) begin
                drop_next = drop_reg - 2'd1;
            end
            if (rsp_live) begin
                rsp_pc_next = rsp_pc_reg + 32'd4;
            end

            if (stall) begin
                buf_push = rsp_live;
            end else if (!buf_empty) begin
                id_valid_next = 1'b1;
                id_pc_next    = buf_head.pc;
                id_instr_next = buf_head.instr;
                buf_pop       = 1'b1;
                buf_push      = rsp_live;
            end else if (rsp_live) begin
                id_valid_next = 1'b1;
                id_pc_next    = rsp_pc_reg;
                id_instr_next = imem_rsp_data;
            end else begin
                id_valid_next = 1'b0;
                id_instr_next = NOP_INSTR;
            end
        end
    end

    // State registers; reset abandons all outstanding work.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            inflight_reg <= 2'd0;
            drop_reg     <= 2'd0;
            id_valid_reg <= 1'b0;
            id_pc_reg    <= '0;
            id_instr_reg <= NOP_INSTR;
        end else begin
            pc_reg       <= pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
            id_valid_reg <= id_valid_next;
            id_pc_reg    <= id_pc_next;
            id_instr_reg <= id_instr_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-1 memory model, stall, redirect,
// redirect+stall, memory back-pressure and mid-stream reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int checks = 0;
    int errors = 0;

    logic        rsp_en;
    logic [31:0] pend_q[$];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hABCD_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    // Present the oldest pending request's data when the memory is enabled.
    task automatic drive_rsp();
        if (rsp_en && pend_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    // One clock: sample handshakes before the edge, update the memory model
    // after it, then drive the next response on the falling edge.
    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        logic        taken;
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        taken    = imem_rsp_valid;
        @(posedge clk);
        if (taken) void'(pend_q.pop_front());
        if (acc) pend_q.push_back(acc_addr);
        @(negedge clk);
        drive_rsp();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        rsp_en = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h13);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Back-to-back fetch, latency-1 memory
        rst = 1'b0; #1;
        chk("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        tick();                                                    // E1
        chk("e1_id_valid", {31'b0, id_valid}, 32'd0);
        chk("e1_req_addr", imem_req_addr, 32'h4);
        tick();                                                    // E2
        chk("e2_id_pc", id_pc, 32'h0);
        chk("e2_id_instr", id_instr, 32'hABCD_0000);
        chk("e2_req_addr", imem_req_addr, 32'h8);
        tick();                                                    // E3
        chk("e3_id_pc", id_pc, 32'h4);
        tick();                                                    // E4
        chk("e4_id_pc", id_pc, 32'h8);
        chk("e4_id_instr", id_instr, 32'hABCD_0008);

        // Stall for three cycles while responses keep arriving
        stall = 1'b1; #1;
        tick();                                                    // E5
        chk("st1_id_pc", id_pc, 32'h8);
        tick();                                                    // E6
        chk("st2_id_pc", id_pc, 32'h8);
        chk("st2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();                                                    // E7
        chk("st3_id_pc", id_pc, 32'h8);
        chk("st3_id_instr", id_instr, 32'hABCD_0008);
        chk("st3_req_valid", {31'b0, imem_req_valid}, 32'd0);
        stall = 1'b0; #1;
        tick();                                                    // E8
        chk("rel1_id_pc", id_pc, 32'hC);
        chk("rel1_id_instr", id_instr, 32'hABCD_000C);
        chk("rel1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rel1_req_addr", imem_req_addr, 32'h14);
        tick();                                                    // E9
        chk("rel2_id_pc", id_pc, 32'h10);
        tick();                                                    // E10
        chk("rel3_id_pc", id_pc, 32'h14);

        // Redirect with two requests outstanding
        rsp_en = 1'b0; drive_rsp();
        tick();                                                    // E11
        chk("pre_rd_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("pre_rd_id_valid", {31'b0, id_valid}, 32'd0);
        chk("pre_rd_id_instr", id_instr, 32'h13);
        redirect_valid = 1'b1; redirect_pc = 32'h103; rsp_en = 1'b1; drive_rsp();
        chk("rd_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();                                                    // E12
        redirect_valid = 1'b0; #1;
        chk("rd_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rd_req_addr", imem_req_addr, 32'h100);
        tick();                                                    // E13
        chk("rd_stale_valid", {31'b0, id_valid}, 32'd0);
        chk("rd_stale_instr", id_instr, 32'h13);
        tick();                                                    // E14
        chk("rd_new_id_pc", id_pc, 32'h100);
        chk("rd_new_instr", id_instr, 32'hABCD_0100);

        // Redirect and stall together: flush wins
        redirect_valid = 1'b1; redirect_pc = 32'h200; stall = 1'b1; #1;
        tick();                                                    // E15
        redirect_valid = 1'b0; stall = 1'b0; #1;
        chk("rs_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rs_id_instr", id_instr, 32'h13);
        chk("rs_req_addr", imem_req_addr, 32'h200);
        tick();                                                    // E16
        tick();                                                    // E17
        chk("rs_new_id_pc", id_pc, 32'h200);

        // Memory not ready for four cycles
        imem_req_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            tick();                                                // E18..E21
            chk("nr_req_addr", imem_req_addr, 32'h208);
            chk("nr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        end
        chk("nr_id_pc", id_pc, 32'h204);
        imem_req_ready = 1'b1; #1;
        tick();                                                    // E22
        chk("nr_after_addr", imem_req_addr, 32'h20C);

        // Reset with one request outstanding; its response lands after reset
        rsp_en = 1'b0; drive_rsp();
        rst = 1'b1; #1;
        tick();                                                    // E23
        chk("mr_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("mr_id_valid", {31'b0, id_valid}, 32'd0);
        chk("mr_id_pc", id_pc, 32'h0);
        rst = 1'b0; rsp_en = 1'b1; drive_rsp();
        chk("mr_first_addr", imem_req_addr, 32'h0);
        chk("mr_first_valid", {31'b0, imem_req_valid}, 32'd1);
        tick();                                                    // E24
        chk("mr_ignored_valid", {31'b0, id_valid}, 32'd0);
        chk("mr_ignored_instr", id_instr, 32'h13);
        tick();                                                    // E25
        chk("mr_new_id_valid", {31'b0, id_valid}, 32'd1);
        chk("mr_new_id_pc", id_pc, 32'h0);
        chk("mr_new_instr", id_instr, 32'hABCD_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, giving the fetch-buffer entries; only 2 is required.
REQ-003 SHALL use one clock, clk (input, 1), with all state updated on its rising edge.
REQ-004 SHALL use reset rst (input, 1), synchronous and active-high.
REQ-005 SHALL have ports:
- stall in 1: hazard hold request; ID outputs hold their value.
- redirect_valid in 1: branch/jump taken; flush and refetch.
- redirect_pc in 32: redirect target.
- imem_req_valid out 1 and imem_req_addr out 32: fetch request.
- imem_req_ready in 1: memory accepts the request.
- imem_rsp_valid in 1 and imem_rsp_data in 32: in-order instruction return, latency >= 1 cycle.
- id_valid out 1: the ID-stage instruction is real.
- id_pc out 32: PC of id_instr.
- id_instr out 32: instruction word to decode and immediate generation.

Function
REQ-006 SHALL hold a fetch PC; a request is accepted when imem_req_valid && imem_req_ready, then PC <= PC+4.
REQ-007 SHALL drive imem_req_addr = PC with bits [1:0] always 0.
REQ-008 SHALL assert imem_req_valid only when inflight + buf_count < BUF_DEPTH, rst=0 and redirect_valid=0.
REQ-009 SHALL count inflight (0..2): +1 on each accepted request, -1 on each counted response, both in the same cycle allowed.
REQ-010 SHALL ignore imem_rsp_valid while inflight==0.
REQ-011 SHALL keep a drop counter; a response arriving while drop>0 is discarded, with drop-1 and inflight-1.
REQ-012 SHALL, on redirect_valid, in the same edge:
- set PC <= {redirect_pc[31:2],2'b00};
- empty the buffer;
- set id_valid <= 0 and id_instr <= NOP (32'h0000_0013);
- set drop <= inflight minus any response arriving that cycle;
- discard that cycle's response.
REQ-013 SHALL give redirect_valid priority over stall, rsp and buffer activity.
REQ-014 SHALL, when stall=0, redirect=0 and the buffer is non-empty, load the buffer head into id_pc/id_instr, set id_valid=1 and pop.
REQ-015 SHALL, when stall=0, the buffer is empty and a live response arrives, bypass the response directly to ID (1-cycle fetch-to-ID latency) and also clear its inflight count.
REQ-016 SHALL, when stall=0 and nothing is available, set id_valid=0 and id_instr=NOP, and hold id_pc.
REQ-017 SHALL, when stall=1, hold id_valid/id_pc/id_instr and write any live response to the buffer.
REQ-018 SHALL tag each buffer entry with its PC, which equals the request address, kept in a response-PC register.
REQ-019 SHALL never let the buffer overflow, guaranteed by REQ-008; a simultaneous push and pop on a full buffer is legal.
REQ-020 SHALL keep id_instr == NOP whenever id_valid==0, so decode never receives an undefined opcode.

Reset
REQ-021 SHALL, on rst=1 at the edge, set:
- PC=RESET_PC;
- inflight=0, drop=0, buffer empty;
- id_valid=0, id_pc=0, id_instr=NOP.
REQ-022 SHALL hold imem_req_valid=0 while rst=1, and SHALL resume requesting the cycle after rst deasserts.
REQ-023 SHALL ignore stall, redirect and rsp inputs during reset; reset mid-stream discards all pending work.

Structure
REQ-024 SHALL take XLEN=32, the NOP constant 32'h0000_0013 and the default RESET_PC from shared package riscv_pkg.
REQ-025 SHALL implement the buffer as sub-module fetch_fifo: 2 entries of {pc,instr}, with push, pop, count, full and empty.

Verification
REQ-026 SHALL cover reset then always-ready memory with latency 1: addrs 0x0,0x4,0x8 issue back-to-back, and id_pc follows 0x0,0x4,0x8 one cycle after each response.
REQ-027 SHALL cover stall held 3 cycles with rsp continuing: id outputs frozen, buffer fills to 2, req_valid drops, and the order is preserved after release.
REQ-028 SHALL cover redirect to 0x103 with 2 in flight: next req_addr=0x100, both stale responses discarded, first id_pc after is 0x100, with id_valid=0 and id_instr=0x13 in between.
REQ-029 SHALL cover redirect and stall in the same cycle: the flush wins and id_valid=0 next cycle.
REQ-030 SHALL cover imem_req_ready=0 for 4 cycles: req_addr held stable and PC not incremented.
REQ-031 SHALL cover rst asserted with 1 in flight and a response arriving after reset: the response is ignored, and the first request is RESET_PC.
